// File: rtl/adc_seq_pkg.sv
// Shared types and default constants for the ADC channel sequencer.
// The optional handshake timeout is enabled by defining ADC_SEQ_TIMEOUT_EN.
package adc_seq_pkg;

    localparam int NUM_CH_DEF      = 4;
    localparam int DATA_W_DEF      = 12;
    localparam int PERIOD_W_DEF    = 16;
    localparam int TIMEOUT_CYC_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        STORE     = 3'd4
    } seq_state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int lowest_set(input logic [31:0] m);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            idx = m[i] ? i : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/adc_seq_chan_sel.sv
// Combinational finder for the next enabled channel above the current one.
// `last` is high when no enabled channel lies above cur_chan.
module adc_seq_chan_sel
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur_chan,
    output logic [CH_W-1:0]   next_chan,
    output logic              last
);

    // Scan downward so the lowest qualifying channel wins.
    always_comb begin
        next_chan = cur_chan;
        last      = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            next_chan = (mask[i] && (i > int'(cur_chan))) ? CH_W'(i) : next_chan;
            last      = (mask[i] && (i > int'(cur_chan))) ? 1'b0 : last;
        end
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Sweeps enabled ADC channels through the SPI engine, compensating its one-conversion
// result latency. Define ADC_SEQ_TIMEOUT_EN to add the handshake timeout and timeout_err.
module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int PERIOD_W    = PERIOD_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        chan_mask,
    input  logic [PERIOD_W-1:0]      period,
    output logic                     spi_start,
    output logic [CH_W-1:0]          spi_chan,
    input  logic                     spi_ready,
    input  logic [DATA_W-1:0]        spi_data,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     sweep_done,
    output logic                     busy
`ifdef ADC_SEQ_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    seq_state_t                state_r;
    logic [PERIOD_W-1:0]       per_cnt_r;
    logic [NUM_CH-1:0]         mask_r;
    logic [CH_W-1:0]           chan_r;
    logic [CH_W-1:0]           prev_chan_r;
    logic                      first_conv_r;
    logic                      flush_r;
    logic                      spi_start_r;
    logic                      sweep_done_r;
    logic                      busy_r;
    logic [NUM_CH*DATA_W-1:0]  ch_data_r;
    logic [NUM_CH-1:0]         ch_valid_r;

    logic                      wrap_s;
    logic                      accept_s;
    logic [CH_W-1:0]           first_live_s;
    logic [CH_W-1:0]           first_lat_s;
    logic [CH_W-1:0]           next_chan_s;
    logic                      last_s;
    logic                      to_hit_s;

    assign wrap_s       = (period == '0) || (per_cnt_r == (period - PERIOD_W'(1)));
    assign accept_s     = enable && wrap_s && (state_r == IDLE) && (chan_mask != '0);
    assign first_live_s = CH_W'(lowest_set(32'(chan_mask)));
    assign first_lat_s  = CH_W'(lowest_set(32'(mask_r)));

    adc_seq_chan_sel #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_chan_sel (
        .mask      (mask_r),
        .cur_chan  (chan_r),
        .next_chan (next_chan_s),
        .last      (last_s)
    );

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_r;
    logic            timeout_err_r;

    // Flags the last permitted waiting cycle of a handshake.
    assign to_hit_s = ((state_r == WAIT_ACK) || (state_r == WAIT_DONE)) &&
                      (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

    // Handshake wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if ((state_r == WAIT_ACK) || (state_r == WAIT_DONE)) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= '0;
            end
            if (to_hit_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign to_hit_s = 1'b0;
`endif

    // Sweep period counter; held at zero while disabled and reloaded at each sweep start.
    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt_r <= '0;
        end else if (!enable || accept_s || wrap_s) begin
            per_cnt_r <= '0;
        end else begin
            per_cnt_r <= per_cnt_r + PERIOD_W'(1);
        end
    end

    // Conversion sequencing FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            mask_r       <= '0;
            chan_r       <= '0;
            prev_chan_r  <= '0;
            first_conv_r <= 1'b0;
            flush_r      <= 1'b0;
            spi_start_r  <= 1'b0;
            sweep_done_r <= 1'b0;
            busy_r       <= 1'b0;
            ch_data_r    <= '0;
            ch_valid_r   <= '0;
        end else begin
            spi_start_r  <= 1'b0;
            sweep_done_r <= 1'b0;
            ch_valid_r   <= '0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mask_r       <= chan_mask;
                        chan_r       <= first_live_s;
                        first_conv_r <= 1'b1;
                        flush_r      <= 1'b0;
                        spi_start_r  <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= START;
                    end else begin
                        busy_r       <= 1'b0;
                    end
                end
                START: begin
                    state_r <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (to_hit_s) begin
                        sweep_done_r <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else if (!spi_ready) begin
                        state_r <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (to_hit_s) begin
                        sweep_done_r <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else if (spi_ready) begin
                        // This result belongs to the previously selected channel.
                        if (!first_conv_r) begin
                            ch_data_r[prev_chan_r*DATA_W +: DATA_W] <= spi_data;
                            ch_valid_r[prev_chan_r]                 <= 1'b1;
                        end
                        sweep_done_r <= flush_r;
                        state_r      <= STORE;
                    end
                end
                STORE: begin
                    if (flush_r) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        chan_r       <= last_s ? first_lat_s : next_chan_s;
                        flush_r      <= last_s;
                        prev_chan_r  <= chan_r;
                        first_conv_r <= 1'b0;
                        spi_start_r  <= 1'b1;
                        state_r      <= START;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign spi_start  = spi_start_r;
    assign spi_chan   = chan_r;
    assign ch_data    = ch_data_r;
    assign ch_valid   = ch_valid_r;
    assign sweep_done = sweep_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Directed self-checking bench for adc_channel_sequencer with a behavioural SPI engine.
// Exercises the timeout path as well when built with ADC_SEQ_TIMEOUT_EN.
module tb_adc_channel_sequencer;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TO_CYC = 64;
`else
    localparam int TO_CYC = 4096;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  chan_mask;
    logic [15:0] period;
    logic        spi_start;
    logic [1:0]  spi_chan;
    logic        spi_ready;
    logic [11:0] spi_data;
    logic [47:0] ch_data;
    logic [3:0]  ch_valid;
    logic        sweep_done;
    logic        busy;
`ifdef ADC_SEQ_TIMEOUT_EN
    logic        timeout_err;
`endif

    adc_channel_sequencer #(
        .NUM_CH      (4),
        .DATA_W      (12),
        .PERIOD_W    (16),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .chan_mask   (chan_mask),
        .period      (period),
        .spi_start   (spi_start),
        .spi_chan    (spi_chan),
        .spi_ready   (spi_ready),
        .spi_data    (spi_data),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .sweep_done  (sweep_done),
        .busy        (busy)
`ifdef ADC_SEQ_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Engine model controls (written by the main sequence only).
    int          conv_len = 5;
    logic [11:0] base     = 12'h100;
    bit          hold     = 1'b0;

    // Monitor state (written by the monitor only).
    int       cyc       = 0;
    int       start_cnt = 0;
    int       in_sweep  = 0;
    int       sw_cnt    = 0;
    int       sw_start[16];
    logic [1:0] chan_log[256];
    int       vcnt[4] = '{0, 0, 0, 0};

    int s0;
    int sw0;
    int v0[4];
    int exp_v[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sweep_done !== 1'b1 && n < max_cyc);
        check(tag, sweep_done, 1'b1);
    endtask

    task automatic wait_starts(input string tag, input int target, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (start_cnt < target && n < max_cyc);
        check(tag, start_cnt >= target, 1'b1);
    endtask

    // SPI engine: result of a conversion is base + channel of the previous select.
    initial begin
        logic [1:0]  prev_sel;
        logic [11:0] nxt;
        prev_sel  = 2'd0;
        spi_ready = 1'b1;
        spi_data  = 12'h000;
        forever begin
            @(posedge clk);
            #2;
            if (spi_start === 1'b1) begin
                nxt       = base + {10'd0, prev_sel};
                prev_sel  = spi_chan;
                spi_ready = 1'b0;
                if (!hold) begin
                    repeat (conv_len) @(posedge clk);
                    #2;
                    spi_data  = nxt;
                    spi_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: start pulses, selected channels, sweep start cycles, ch_valid counts.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (spi_start === 1'b1) begin
                if (start_cnt < 256) chan_log[start_cnt] = spi_chan;
                if (in_sweep == 0 && sw_cnt < 16) begin
                    sw_start[sw_cnt] = cyc;
                    sw_cnt++;
                end
                in_sweep++;
                start_cnt++;
            end
            if (sweep_done === 1'b1) in_sweep = 0;
            for (int i = 0; i < 4; i++) begin
                if (ch_valid[i] === 1'b1) vcnt[i]++;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        chan_mask = 4'b0000;
        period    = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_spi_start", spi_start, 1'b0);
        check("rst_spi_chan", spi_chan, 2'd0);
        check("rst_ch_data", ch_data, 48'h0);
        check("rst_ch_valid", ch_valid, 4'b0000);
        check("rst_sweep_done", sweep_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Four-channel sweep, back-to-back period.
        s0 = start_cnt;
        base = 12'h100;
        chan_mask = 4'b1111;
        enable = 1'b1;
        wait_done("t1_done", 300);
        enable = 1'b0;
        check("t1_ch_data", ch_data, 48'h103102101100);
        check("t1_valid_at_done", ch_valid, 4'b1000);
        check("t1_busy_at_done", busy, 1'b1);
        check("t1_starts", start_cnt - s0, 5);
        check("t1_chan_seq", {chan_log[s0], chan_log[s0+1], chan_log[s0+2],
                              chan_log[s0+3], chan_log[s0+4]}, 10'b00_01_10_11_00);
        @(negedge clk);
        check("t1_busy_after", busy, 1'b0);
        check("t1_done_pulse", sweep_done, 1'b0);

        // Sparse mask: channels 0 and 2 keep their data.
        repeat (3) @(negedge clk);
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) v0[i] = vcnt[i];
        base = 12'h200;
        chan_mask = 4'b1010;
        enable = 1'b1;
        wait_done("t2_done", 300);
        enable = 1'b0;
        check("t2_ch_data", ch_data, 48'h203102201100);
        check("t2_starts", start_cnt - s0, 3);
        check("t2_chan_seq", {chan_log[s0], chan_log[s0+1], chan_log[s0+2]}, 6'b01_11_01);
        @(negedge clk);
        exp_v = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_valid_cnt%0d", i), vcnt[i] - v0[i], exp_v[i]);
        end

        // Period spacing with a mask change during the first sweep.
        repeat (3) @(negedge clk);
        s0 = start_cnt;
        sw0 = sw_cnt;
        base = 12'h300;
        conv_len = 60;
        period = 16'd1000;
        chan_mask = 4'b0011;
        enable = 1'b1;
        wait_starts("t3_first_start", s0 + 1, 1100);
        chan_mask = 4'b1100;
        wait_done("t3_done1", 400);
        check("t3_seq1", {chan_log[s0], chan_log[s0+1], chan_log[s0+2]}, 6'b00_01_00);
        wait_done("t3_done2", 1200);
        enable = 1'b0;
        check("t3_seq2", {chan_log[s0+3], chan_log[s0+4], chan_log[s0+5]}, 6'b10_11_10);
        check("t3_spacing", sw_start[sw0+1] - sw_start[sw0], 1000);
        check("t3_ch_data", ch_data, 48'h303302301300);

        // Zero mask never starts; disabling mid-sweep lets the sweep finish.
        repeat (3) @(negedge clk);
        conv_len = 5;
        period = 16'd0;
        chan_mask = 4'b0000;
        s0 = start_cnt;
        enable = 1'b1;
        repeat (50) @(negedge clk);
        check("t4_zero_mask_starts", start_cnt - s0, 0);
        check("t4_zero_mask_busy", busy, 1'b0);
        chan_mask = 4'b1111;
        wait_starts("t4_started", s0 + 1, 20);
        enable = 1'b0;
        wait_done("t4_done", 300);
        check("t4_full_sweep", start_cnt - s0, 5);
        repeat (30) @(negedge clk);
        check("t4_no_more_starts", start_cnt - s0, 5);
        check("t4_idle_busy", busy, 1'b0);

        // Reset while waiting for a conversion, then a clean sweep.
        base = 12'h500;
        conv_len = 20;
        s0 = start_cnt;
        enable = 1'b1;
        wait_starts("t5_second_start", s0 + 2, 100);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("t5_rst_spi_start", spi_start, 1'b0);
        check("t5_rst_spi_chan", spi_chan, 2'd0);
        check("t5_rst_ch_data", ch_data, 48'h0);
        check("t5_rst_ch_valid", ch_valid, 4'b0000);
        check("t5_rst_sweep_done", sweep_done, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        reset = 1'b0;
        for (int n = 0; n < 40 && spi_ready !== 1'b1; n++) @(negedge clk);
        check("t5_engine_idle", spi_ready, 1'b1);
        @(negedge clk);
        s0 = start_cnt;
        enable = 1'b1;
        wait_done("t5_done", 600);
        enable = 1'b0;
        check("t5_ch_data", ch_data, 48'h503502501500);
        check("t5_starts", start_cnt - s0, 5);

`ifdef ADC_SEQ_TIMEOUT_EN
        // Engine never completes: sweep abandoned with the sticky error.
        repeat (3) @(negedge clk);
        hold = 1'b1;
        chan_mask = 4'b0001;
        enable = 1'b1;
        wait_done("t6_done", 200);
        enable = 1'b0;
        check("t6_timeout_err", timeout_err, 1'b1);
        check("t6_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        check("t6_err_sticky", timeout_err, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_channel_sequencer.md
# adc_channel_sequencer

Sequences multi-channel conversions through the SPI ADC state machine (start/ready handshake, 12-bit result). Sweeps the enabled channels in ascending order on a programmable period and compensates the ADC's one-conversion result pipeline. Stores the latest result per channel for downstream display and LED logic. Sits between system control (enable, mask, period) and the SPI engine; it is the engine's only driver of `start`.

## Interface
- `NUM_CH`, 4: number of channels; `spi_chan` width is `CH_W` = clog2(`NUM_CH`).
- `DATA_W`, 12: ADC result width.
- `PERIOD_W`, 16: width of the sweep period.
- `TIMEOUT_CYC`, 4096: handshake timeout limit. Used only with `ADC_SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock. All logic is in this domain.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: permits new sweeps.
- `chan_mask` in `NUM_CH`: enabled channels. Bit i enables channel i.
- `period` in `PERIOD_W`: cycles from one sweep start to the next. 0 means back-to-back sweeps.
- `spi_start` out 1: one-cycle start pulse to the SPI engine.
- `spi_chan` out `CH_W`: channel select for the conversion being started.
- `spi_ready` in 1: high when the engine is idle. Its rising edge means `spi_data` is valid.
- `spi_data` in `DATA_W`: conversion result.
- `ch_data` out `NUM_CH*DATA_W`: per-channel latest result. Channel i occupies bits [i*DATA_W +: DATA_W].
- `ch_valid` out `NUM_CH`: one-cycle pulse when channel i is updated.
- `sweep_done` out 1: one-cycle pulse at the end of each sweep.
- `busy` out 1: high whenever the state is not IDLE.
- `timeout_err` out 1: sticky error flag. Exists only with `ADC_SEQ_TIMEOUT_EN`.

## Operation
- **Reset values:** state IDLE. `spi_start`=0, `spi_chan`=0, `ch_data`=0, `ch_valid`=0, `sweep_done`=0, `busy`=0, `timeout_err`=0. The period counter is cleared.
- **Period counter:** free-runs while `enable`=1 and counts 0..`period`-1. It reloads to 0 at each sweep start.
- **Sweep trigger:** a sweep becomes pending when the counter wraps (or immediately when `period`=0). A pending trigger is accepted only in IDLE and only when `chan_mask`≠0. Triggers arriving while `busy` are dropped, not queued.
- **Mask latch:** `chan_mask` is latched at sweep start. Changes during a sweep take effect on the next sweep.
- **Pipeline compensation:** the result returned by conversion k belongs to the channel selected at conversion k-1.
  - With m enabled channels, a sweep issues m+1 conversions.
  - Conversions 0..m-1 select the enabled channels in ascending order. Conversion m re-selects the first enabled channel as a flush.
  - The result of conversion 0 is discarded. The result of conversion k (k≥1) is written to the channel selected at conversion k-1.
- **States:**
  - IDLE → START on an accepted trigger.
  - START: assert `spi_start` for one cycle with `spi_chan` valid → WAIT_ACK.
  - WAIT_ACK: wait for `spi_ready`=0 → WAIT_DONE.
  - WAIT_DONE: wait for `spi_ready`=1 → STORE.
  - STORE: write `ch_data` (unless k=0) and pulse `ch_valid`. Then go to START if conversions remain; otherwise pulse `sweep_done` and go to IDLE.
- **Enable deasserted mid-sweep:** the current sweep completes. No new sweep starts.
- **Single enabled channel (m=1):** two conversions on the same channel; one store.
- **Reset mid-conversion:** immediate return to IDLE with reset values. The SPI engine is not aborted; the sequencer waits in IDLE for the next trigger.

## Timing
- `spi_start` is high exactly one cycle, in START. `spi_chan` is stable from START until the next START.
- `spi_data` is sampled in the cycle `spi_ready` is seen high in WAIT_DONE. `ch_data` updates one cycle later (STORE). `ch_valid` is high in that same cycle.
- The sequencer adds 3 cycles of overhead per conversion: START, the first WAIT_ACK cycle, and STORE.
- `sweep_done` coincides with the final STORE cycle.
- `busy` rises the cycle after the trigger is accepted. It falls the cycle after `sweep_done`.

## Configuration
- `ADC_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT_ACK and WAIT_DONE and clears on entry to START.
  - If it reaches `TIMEOUT_CYC`, set `timeout_err` (cleared only by `reset`), abandon the sweep without storing, pulse `sweep_done`, and return to IDLE.
- `ADC_SEQ_TIMEOUT_EN` undefined: no counter and no `timeout_err` port. The sequencer waits indefinitely.

## Structure
- Shared package `adc_seq_pkg`: state enum (IDLE, START, WAIT_ACK, WAIT_DONE, STORE) and default parameter constants.
- One sub-module, `adc_seq_chan_sel`: combinational next-enabled-channel finder. Inputs: latched mask and current channel. Outputs: next channel and a `last` flag.

## Test plan
- **Four-channel sweep:** mask=4'b1111, period=0, model returns 0x100+chan_of_previous_select → ch_data = 0x100, 0x101, 0x102, 0x103. Five `spi_start` pulses; `sweep_done` after the fifth STORE.
- **Sparse mask:** mask=4'b1010 → `spi_chan` sequence 1, 3, 1. `ch_valid` pulses only on bits 1 and 3; channels 0 and 2 keep their prior data.
- **Period spacing:** period=1000 with a 60-cycle model conversion → sweep starts exactly 1000 cycles apart. A mask change mid-sweep applies only to the next sweep.
- **Zero mask and disable:** mask=0 → no `spi_start` ever. Deasserting `enable` mid-sweep → the sweep completes, then no further `spi_start`.
- **Reset mid-conversion:** `reset` in WAIT_DONE → all outputs return to reset values on the next cycle. A clean sweep follows after the next trigger.
- **Timeout (`ADC_SEQ_TIMEOUT_EN`, `TIMEOUT_CYC`=64):** model holds `spi_ready`=0 → `timeout_err`=1 at cycle 64 of waiting, `sweep_done` pulse, return to IDLE.
